seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle radix-2 non-restoring integer divider. It is the inverse companion of the Booth multiplier.
//  Computes quotient and remainder of dividend/divisor, one quotient bit per clock.
//  Sits beside the Booth multiplier datapath and reuses the same add/subtract style for each trial step.
// PARAMETERS
//  WIDTH  8  operand, quotient and remainder width in bits (>=2)
// PORTS
//  clk          in   1      rising-edge clock; the only clock
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      request; sampled only when busy==0
//  dividend     in   WIDTH  numerator; sampled on the accepting edge
//  divisor      in   WIDTH  denominator; sampled on the accepting edge
//  busy         out  1      high from the accepting edge until done is high
//  done         out  1      one-cycle pulse: results are valid
//  quotient     out  WIDTH  result; held until the next accepted start
//  remainder    out  WIDTH  result; held until the next accepted start
//  div_by_zero  out  1      set with done when divisor==0; held like the results
// BEHAVIOUR
//  Reset (async, any state): state=IDLE. All outputs are 0, and internal A/Q/M/count are 0.
//  Reset mid-operation aborts the operation. No done is issued for the aborted operation.
//  States:
//   - IDLE -> CALC on start & divisor!=0.
//   - IDLE -> DONE on start & divisor==0.
//   - CALC -> CALC while count<WIDTH-1, then -> FIX.
//   - FIX -> DONE.
//   - DONE -> IDLE.
//  Accept edge: load A=0 (WIDTH+1 bits), Q=|dividend|, M=|divisor| (WIDTH+1 bits, zero-extended).
//  On the accept edge, count=0, busy=1, done=0 and div_by_zero=0.
//  CALC edge: shift {A,Q} left by 1.
//   - If the old A is non-negative, A=A-M; otherwise A=A+M.
//   - Set Q[0]=~A[WIDTH] (the new A).
//   - count++.
//  FIX edge: if A<0 then A=A+M. Drive quotient=Q and remainder=A[WIDTH-1:0] (after sign fix-up).
//  DONE: done=1 for exactly one cycle, then busy=0. The DONE->IDLE edge clears done.
//  Latency: done is high after edge WIDTH+2 counted from the accept edge (edge 0).
//   - WIDTH=8: done after edge 10; busy covers edges 0..9.
//  Divide by zero: done is high after edge 1.
//   - quotient = all ones, remainder = dividend, div_by_zero = 1.
//  start while busy: ignored. Operands may change freely while busy.
//  start in the same cycle that done is high: ignored (busy is still 1). It is accepted from IDLE on the next cycle.
//  Arithmetic is modulo 2^(WIDTH+1) inside A. Outputs are truncated to WIDTH bits.
// CONFIGURATION
//  Macro DIV_SIGNED_EN.
//  Defined: operands are two's complement. The magnitudes are divided.
//   - quotient is negated when the operand signs differ.
//   - remainder takes the sign of the dividend (truncating division).
//   - MIN/-1 (e.g. -128/-1) gives quotient=MIN (wraps) and remainder=0, with no flag.
//   - Divide by zero: quotient = -1 (all ones), remainder = dividend (sign kept).
//   - Sign fix-up happens on the FIX edge. Latency is unchanged.
//  Undefined: all operands and results are unsigned. No sign logic is synthesized.
// STRUCTURE
//  Package div_pkg:
//   - typedef div_state_t {IDLE, CALC, FIX, DONE}, 2-bit encoding 0..3.
//   - localparam DIV_WIDTH_DEF=8.
//   - localparam CNT_W=$clog2(WIDTH).
//  Sub-module div_addsub: combinational (WIDTH+1)-bit unit.
//   - Z = add_n_sub ? a+b : a-b.
//   - Used for the CALC step and the FIX restore.
//  FSM, shift registers and counter live in seq_divider.
// TESTING
//  1. 100/7 (unsigned) -> quotient=14, remainder=2, done after edge 10, busy=1 on edges 0..9.
//  2. 255/1 -> quotient=255, remainder=0. Then 3/10 -> quotient=0, remainder=3.
//  3. 5/0 -> done after edge 1, div_by_zero=1, quotient=0xFF, remainder=5.
//     A following 9/3 clears the flag and gives quotient=3, remainder=0.
//  4. Start 200/9, then pulse start=1 with 50/5 on edge 4.
//     -> second request ignored; result quotient=22, remainder=2.
//  5. Start 100/7, assert rst between edges 3 and 4.
//     -> all outputs 0 immediately; no done pulse; next 100/7 completes normally.
//  6. DIV_SIGNED_EN: -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2).
//     -128/-1 -> quotient=0x80, remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg: shared types and constants for the sequential divider.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH_DEF = 8;

    // A 1-bit counter is still needed when the operand width is 2.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DIV_WIDTH_DEF);

endpackage

`default_nettype wire

// File: rtl/div_addsub.sv
// ============================================================================
// div_addsub: combinational add/subtract unit used for trial steps and restore.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module div_addsub #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_n_sub,
    output logic [WIDTH-1:0] z
);

    assign z = add_n_sub ? (a + b) : (a - b);

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider: radix-2 non-restoring divider, one quotient bit per clock.
// Optional signed operation is enabled with the DIV_SIGNED_EN macro.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                 C_CNT_W    = cnt_width(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);

    div_state_t         state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;

    logic               w_accept;
    logic               w_div_zero;
    logic [WIDTH:0]     w_au_a;
    logic               w_au_add;
    logic [WIDTH:0]     w_au_z;
    logic [WIDTH:0]     w_a_fix;
    logic [WIDTH-1:0]   w_q_load;
    logic [WIDTH:0]     w_m_load;
    logic [WIDTH-1:0]   w_q_res;
    logic [WIDTH-1:0]   w_r_res;

`ifdef DIV_SIGNED_EN
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
`endif

    // The done cycle is still treated as busy, so a start there is ignored.
    assign w_accept   = start && (state_q == IDLE) && !done_q;
    assign w_div_zero = (divisor == '0);

    // One shared unit: trial add/sub while iterating, restore add on FIX.
    assign w_au_a   = (state_q == CALC) ? {a_q[WIDTH-1:0], q_q[WIDTH-1]} : a_q;
    assign w_au_add = (state_q == CALC) ? a_q[WIDTH] : 1'b1;

    div_addsub #(
        .WIDTH     (WIDTH + 1)
    ) u_addsub (
        .a         (w_au_a),
        .b         (m_q),
        .add_n_sub (w_au_add),
        .z         (w_au_z)
    );

    assign w_a_fix = a_q[WIDTH] ? w_au_z : a_q;

`ifdef DIV_SIGNED_EN
    // Divide-by-zero keeps the raw dividend in Q so it can be returned as-is.
    assign w_q_load = (w_div_zero || !dividend[WIDTH-1]) ? dividend : -dividend;
    assign w_m_load = {1'b0, (divisor[WIDTH-1] ? -divisor : divisor)};
    assign w_q_res  = negq_q ? -q_q : q_q;
    assign w_r_res  = negr_q ? -w_a_fix[WIDTH-1:0] : w_a_fix[WIDTH-1:0];
`else
    assign w_q_load = dividend;
    assign w_m_load = {1'b0, divisor};
    assign w_q_res  = q_q;
    assign w_r_res  = w_a_fix[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (w_accept) state_d = w_div_zero ? DONE : CALC;
            CALC:    if (count_q == C_CNT_LAST) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef DIV_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (w_accept) begin
                    a_d     = '0;
                    q_d     = w_q_load;
                    m_d     = w_m_load;
                    count_d = '0;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
                    negq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    negr_d  = dividend[WIDTH-1];
`endif
                end
            end
            CALC: begin
                a_d     = w_au_z;
                q_d     = {q_q[WIDTH-2:0], ~w_au_z[WIDTH]};
                count_d = count_q + C_CNT_W'(1);
            end
            FIX: begin
                a_d   = w_a_fix;
                quo_d = w_q_res;
                rem_d = w_r_res;
            end
            DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                if (m_q == '0) begin
                    quo_d = '1;
                    rem_d = q_q;
                    dbz_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef DIV_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef DIV_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// tb_seq_divider: directed self-checking bench for seq_divider (WIDTH=8).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider #(
        .WIDTH       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one division; lat is the edge (after accept edge 0) where done rises.
    // poke>0 pulses a competing start with 50/5 on that edge.
    task automatic run_div(input string name, input logic [7:0] dd, input logic [7:0] dv,
                           input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                           input int lat, input int poke);
        int busy_bad;
        int done_early;
        busy_bad   = 0;
        done_early = 0;
        @(negedge clk);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'hAA;
        divisor  = 8'h55;
        for (int k = 1; k <= lat; k++) begin
            if (!busy) busy_bad++;
            if (done)  done_early++;
            if (k == poke) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check({name, " busy during op"}, busy_bad, 0);
        check({name, " early done"}, done_early, 0);
        check({name, " done"}, done, 1);
        check({name, " busy at done"}, busy, 0);
        check({name, " quotient"}, quotient, eq);
        check({name, " remainder"}, remainder, er);
        check({name, " div_by_zero"}, div_by_zero, edbz);
        @(posedge clk);
        #1;
        check({name, " done pulse width"}, done, 0);
    endtask

    initial begin
        int done_seen;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        run_div("100/7",  8'd100, 8'd7,  8'd14,  8'd2,   1'b0, 10, 0);
        run_div("255/1",  8'd255, 8'd1,  8'd255, 8'd0,   1'b0, 10, 0);
        run_div("3/10",   8'd3,   8'd10, 8'd0,   8'd3,   1'b0, 10, 0);
        run_div("5/0",    8'd5,   8'd0,  8'hFF,  8'd5,   1'b1, 1,  0);
        run_div("9/3",    8'd9,   8'd3,  8'd3,   8'd0,   1'b0, 10, 0);
        run_div("200/9 poked", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 10, 4);

        // Asynchronous reset between edges 3 and 4 of an operation.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst mid busy", busy, 0);
        check("rst mid quotient", quotient, 0);
        check("rst mid remainder", remainder, 0);
        check("rst mid dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("rst abort no done", done_seen, 0);
        run_div("100/7 after rst", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 10, 0);

`ifdef DIV_SIGNED_EN
        run_div("-100/7",   8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, 10, 0);
        run_div("-128/-1",  8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10, 0);
        run_div("-7/0",     8'hF9, 8'd0,  8'hFF, 8'hF9, 1'b1, 1,  0);
`else
        run_div("156/7",    8'd156, 8'd7,   8'd22, 8'd2,   1'b0, 10, 0);
        run_div("128/255",  8'd128, 8'd255, 8'd0,  8'd128, 1'b0, 10, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
